// File: rtl/uart_frame_packer.sv
// uart_frame_packer: snapshots NCH channel words plus a tag byte and
// serialises them as a delimited byte frame over the uart_controller
// TX_DATA / TX_LOAD / TX_LOAD_OKAY handshake, counting refused offers.
module uart_frame_packer #(
  parameter int         NCH       = 2,
  parameter int         W         = 16,
  parameter logic [7:0] SEP       = 8'h2C,
  parameter logic [7:0] TERM      = 8'h0A,
  parameter bit         MSB_FIRST = 1'b0,
  parameter bit         HDR_EN    = 1'b1,
  parameter int         GUARD     = 2
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               en,
  input  logic               frame_valid,
  input  logic [7:0]         frame_tag,
  input  logic [NCH*W-1:0]   frame_data,
  output logic               frame_ready,
  output logic [7:0]         tx_data,
  output logic               tx_load,
  input  logic               tx_okay,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

  // Bytes per channel, header length and total frame length
  localparam int B    = W / 8;
  localparam int HOFF = HDR_EN ? 2 : 0;
  localparam int L    = HOFF + NCH * B + NCH;
  localparam int IW   = (L > 1) ? $clog2(L) : 1;
  localparam int LAST = L - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GUARD
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        guard_q, guard_d;
  logic [7:0]        snap_tag;
  logic [NCH*W-1:0]  snap_data;
  logic [7:0]        tx_data_q;
  logic [7:0]        drop_q;
  logic [7:0]        byte_sel;
  logic              accept;

  // Acceptance is only possible from the registered idle state, never in reset
  assign frame_ready = en & (state_q == ST_IDLE) & ~rst;
  assign accept      = frame_valid & frame_ready;
  assign busy        = (state_q != ST_IDLE);
  assign drop_cnt    = drop_q;

  // Map the byte index onto header, channel byte, separator or terminator
  always_comb begin
    byte_sel = TERM;
    if (HDR_EN && (idx_q == IW'(0))) begin
      byte_sel = snap_tag;
    end else if (HDR_EN && (idx_q == IW'(1))) begin
      byte_sel = SEP;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        for (int j = 0; j <= B; j++) begin
          if (int'(idx_q) == HOFF + k * (B + 1) + j) begin
            if (j == B) begin
              byte_sel = (k == NCH - 1) ? TERM : SEP;
            end else begin
              byte_sel = snap_data[k * W + ((MSB_FIRST != 1'b0) ? (B - 1 - j) : j) * 8 +: 8];
            end
          end
        end
      end
    end
  end

  // Next-state logic and the load strobe; tx_data shows the new byte on the strobe cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    guard_d = guard_q;
    tx_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (tx_okay) begin
          tx_load = 1'b1;
          guard_d = 4'(GUARD);
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        guard_d = guard_q - 4'd1;
        if (guard_q <= 4'd1) begin
          if (idx_q == IW'(LAST)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    tx_data = tx_load ? byte_sel : tx_data_q;
  end

  // State, byte index and guard counter registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      guard_q <= guard_d;
    end
  end

  // Snapshot the offered frame so the inputs are never consulted mid-frame
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      snap_tag  <= '0;
      snap_data <= '0;
    end else if (accept) begin
      snap_tag  <= frame_tag;
      snap_data <= frame_data;
    end
  end

  // Remember the last byte handed to the UART so tx_data holds between strobes
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tx_data_q <= '0;
    end else begin
      tx_data_q <= tx_data;
    end
  end

  // Count refused offers, saturating rather than wrapping
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (frame_valid && !frame_ready && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// tb_uart_frame_packer: directed stimulus against two packer configurations,
// with a byte-queue model of the frame format checked on every cycle.
module tb_uart_frame_packer;

  logic        sys_clk = 1'b0;
  logic        rst, en;
  logic        valid_a, valid_b;
  logic [7:0]  tag;
  logic [31:0] data_a;
  logic [71:0] data_b;
  logic        tx_okay_a, tx_okay_b;
  logic        ready_a, ready_b, tx_load_a, tx_load_b, busy_a, busy_b;
  logic [7:0]  tx_data_a, tx_data_b, drop_a, drop_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_a[$], exp_b[$], cap_a[$], cap_b[$];
  int         cap_cyc_a[$], cap_cyc_b[$];
  logic [7:0] last_a = 8'h00, last_b = 8'h00;
  logic       prev_busy_a = 1'b0;
  int         fall_cyc_a = -1;

  logic [7:0] lit_def [8]  = '{8'h05, 8'h2C, 8'h34, 8'h12, 8'h2C, 8'hCD, 8'hAB, 8'h0A};
  logic [7:0] lit_msb [12] = '{8'h01, 8'h02, 8'h03, 8'h2C, 8'h04, 8'h05, 8'h06, 8'h2C,
                               8'h07, 8'h08, 8'h09, 8'h0A};

  // Clock generation
  always #5 sys_clk = ~sys_clk;

  // Cycle counter used to timestamp strobes
  always @(posedge sys_clk) cyc++;

  uart_frame_packer dut_a (
    .sys_clk(sys_clk), .rst(rst), .en(en), .frame_valid(valid_a), .frame_tag(tag),
    .frame_data(data_a), .frame_ready(ready_a), .tx_data(tx_data_a), .tx_load(tx_load_a),
    .tx_okay(tx_okay_a), .busy(busy_a), .drop_cnt(drop_a)
  );

  uart_frame_packer #(.NCH(3), .W(24), .MSB_FIRST(1'b1), .HDR_EN(1'b0)) dut_b (
    .sys_clk(sys_clk), .rst(rst), .en(en), .frame_valid(valid_b), .frame_tag(tag),
    .frame_data(data_b), .frame_ready(ready_b), .tx_data(tx_data_b), .tx_load(tx_load_b),
    .tx_okay(tx_okay_b), .busy(busy_b), .drop_cnt(drop_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Frame format model: header, channel bytes in chosen order, separators, terminator
  task automatic modelFrame(input int which, input logic [7:0] t, input logic [71:0] d,
                            input int nch, input int w, input bit msb, input bit hdr);
    logic [7:0] q[$];
    int nb;
    nb = w / 8;
    if (hdr) begin
      q.push_back(t);
      q.push_back(8'h2C);
    end
    for (int k = 0; k < nch; k++) begin
      for (int j = 0; j < nb; j++) begin
        int bi;
        bi = msb ? (nb - 1 - j) : j;
        q.push_back(8'(d >> (k * w + 8 * bi)));
      end
      if (k < nch - 1) q.push_back(8'h2C);
    end
    q.push_back(8'h0A);
    foreach (q[i]) begin
      if (which == 0) exp_a.push_back(q[i]);
      else            exp_b.push_back(q[i]);
    end
  endtask

  // Compare process: every strobe must carry the next modelled byte, otherwise tx_data holds
  always @(negedge sys_clk) begin
    checkOutput("ready_a", 32'(ready_a), 32'(en & ~busy_a & ~rst));
    checkOutput("ready_b", 32'(ready_b), 32'(en & ~busy_b & ~rst));
    if (prev_busy_a && !busy_a) fall_cyc_a = cyc;
    prev_busy_a = busy_a;
    if (rst) begin
      last_a = 8'h00;
      last_b = 8'h00;
    end else begin
      if (tx_load_a) begin
        checkOutput("okay_at_load_a", 32'(tx_okay_a), 32'd1);
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_load_a actual=%0h required=none", tx_data_a);
        end else begin
          checkOutput("byte_a", 32'(tx_data_a), 32'(exp_a.pop_front()));
        end
        cap_a.push_back(tx_data_a);
        cap_cyc_a.push_back(cyc);
        last_a = tx_data_a;
      end else begin
        checkOutput("hold_a", 32'(tx_data_a), 32'(last_a));
      end
      if (tx_load_b) begin
        checkOutput("okay_at_load_b", 32'(tx_okay_b), 32'd1);
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_load_b actual=%0h required=none", tx_data_b);
        end else begin
          checkOutput("byte_b", 32'(tx_data_b), 32'(exp_b.pop_front()));
        end
        cap_b.push_back(tx_data_b);
        cap_cyc_b.push_back(cyc);
        last_b = tx_data_b;
      end else begin
        checkOutput("hold_b", 32'(tx_data_b), 32'(last_b));
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Offer one frame for a single cycle; returns the cycle index of the accepting edge
  task automatic applyStimulus(input int which, input logic [7:0] t, input logic [71:0] d,
                               output int acc);
    if (which == 0) modelFrame(0, t, d, 2, 16, 1'b0, 1'b1);
    else            modelFrame(1, t, d, 3, 24, 1'b1, 1'b0);
    tag = t;
    if (which == 0) begin
      data_a  = d[31:0];
      valid_a = 1'b1;
    end else begin
      data_b  = d;
      valid_b = 1'b1;
    end
    tick();
    acc     = cyc;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic waitIdle(input int which);
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      #1;
      if (((which == 0) ? busy_a : busy_b) == 1'b0) break;
    end
    checkOutput("wait_idle", 32'((which == 0) ? busy_a : busy_b), 32'd0);
  endtask

  task automatic waitCaps(input int n);
    for (int i = 0; i < 500; i++) begin
      @(negedge sys_clk);
      #1;
      if (cap_a.size() >= n) break;
    end
    checkOutput("wait_caps", 32'(cap_a.size() >= n), 32'd1);
  endtask

  // Safety net against a hung handshake
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, base, c, base2;
    rst = 1'b1; en = 1'b1; valid_a = 1'b0; valid_b = 1'b0; tag = 8'h00;
    data_a = '0; data_b = '0; tx_okay_a = 1'b1; tx_okay_b = 1'b1;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_ready", 32'(ready_a), 32'd0);
    checkOutput("rst_load", 32'(tx_load_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_drop", 32'(drop_a), 32'd0);
    checkOutput("rst_data", 32'(tx_data_a), 32'd0);
    checkOutput("rst_data_b", 32'(tx_data_b), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("ready_after_rst", 32'(ready_a), 32'd1);

    // Default frame plus snapshot: inputs go all-ones one cycle after acceptance
    applyStimulus(0, 8'h05, {40'h0, 16'hABCD, 16'h1234}, acc);
    tick();
    data_a = '1;
    checkOutput("busy_in_frame", 32'(busy_a), 32'd1);
    waitIdle(0);
    checkOutput("def_len", 32'(cap_a.size()), 32'd8);
    for (int i = 0; i < 8; i++) checkOutput("def_byte_lit", 32'(cap_a[i]), 32'(lit_def[i]));
    checkOutput("def_first_cyc", 32'(cap_cyc_a[0]), 32'(acc));
    for (int i = 1; i < 8; i++)
      checkOutput("def_spacing", 32'(cap_cyc_a[i] - cap_cyc_a[i-1]), 32'd3);
    checkOutput("def_busy_fall", 32'(fall_cyc_a), 32'(acc + 24));

    // Backpressure before byte 3
    base = cap_a.size();
    applyStimulus(0, 8'h3C, {40'h0, 16'h2D3C, 16'h0F1E}, acc);
    waitCaps(base + 2);
    c = cap_cyc_a[base + 1];
    tick();
    tx_okay_a = 1'b0;
    repeat (20) tick();
    checkOutput("stall_no_load", 32'(cap_a.size()), 32'(base + 2));
    tx_okay_a = 1'b1;
    waitCaps(base + 3);
    checkOutput("stall_resume_cyc", 32'(cap_cyc_a[base + 2]), 32'(c + 21));
    waitIdle(0);
    checkOutput("stall_len", 32'(cap_a.size()), 32'(base + 8));

    // MSB-first, headerless, three 24-bit channels
    applyStimulus(1, 8'h00, {24'h070809, 24'h040506, 24'h010203}, acc);
    waitIdle(1);
    checkOutput("msb_len", 32'(cap_b.size()), 32'd12);
    for (int i = 0; i < 12; i++) checkOutput("msb_byte_lit", 32'(cap_b[i]), 32'(lit_msb[i]));
    checkOutput("msb_first_cyc", 32'(cap_cyc_b[0]), 32'(acc));
    checkOutput("msb_span", 32'(cap_cyc_b[11] - cap_cyc_b[0]), 32'd33);

    // Drops while busy, saturating at 255, with the frame left intact
    checkOutput("drop_zero", 32'(drop_a), 32'd0);
    base = cap_a.size();
    applyStimulus(0, 8'h11, {40'h0, 16'hDEAD, 16'hBEEF}, acc);
    waitCaps(base + 1);
    tick();
    tx_okay_a = 1'b0;
    for (int i = 0; i < 300; i++) begin
      valid_a = 1'b1;
      tag     = 8'hFF;
      data_a  = '1;
      tick();
      valid_a = 1'b0;
      tick();
      if (i == 2) checkOutput("drop_three", 32'(drop_a), 32'd3);
    end
    checkOutput("drop_sat", 32'(drop_a), 32'd255);
    checkOutput("drop_busy", 32'(busy_a), 32'd1);
    checkOutput("drop_stalled", 32'(cap_a.size()), 32'(base + 1));
    tx_okay_a = 1'b1;
    waitIdle(0);
    checkOutput("drop_len", 32'(cap_a.size()), 32'(base + 8));
    en = 1'b0;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    tick();
    checkOutput("en_off_not_accepted", 32'(busy_a), 32'd0);
    checkOutput("en_off_drop_sat", 32'(drop_a), 32'd255);
    en = 1'b1;
    tick();

    // Reset in the middle of a frame, then a clean frame starting with its header
    base = cap_a.size();
    applyStimulus(0, 8'h21, {40'h0, 16'h7788, 16'h5566}, acc);
    waitCaps(base + 4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_load", 32'(tx_load_a), 32'd0);
    checkOutput("midrst_busy", 32'(busy_a), 32'd0);
    checkOutput("midrst_ready", 32'(ready_a), 32'd0);
    exp_a.delete();
    tick();
    tick();
    rst = 1'b0;
    checkOutput("midrst_drop", 32'(drop_a), 32'd0);
    checkOutput("midrst_data", 32'(tx_data_a), 32'd0);
    tick();
    base2 = cap_a.size();
    checkOutput("midrst_no_more", 32'(base2), 32'(base + 4));
    applyStimulus(0, 8'h07, {40'h0, 16'h0304, 16'h0102}, acc);
    waitIdle(0);
    checkOutput("post_rst_len", 32'(cap_a.size()), 32'(base2 + 8));
    checkOutput("post_rst_hdr", 32'(cap_a[base2]), 32'h07);

    checkOutput("exp_a_drained", 32'(exp_a.size()), 32'd0);
    checkOutput("exp_b_drained", 32'(exp_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
